// File: rtl/lms_update_sched.sv
// lms_update_sched: per-sample sequencer for the LMS adaptive filter.
// One accepted sample runs FIR MAC over all taps, latches the error, then
// (optionally) issues one weight update per tap. Write-back strobes trail
// the issues by DIV_LAT cycles so each weight register updates only when
// its divided term is valid.
module lms_update_sched #(
    parameter int NTAPS   = 16,
    parameter int IDX_W   = 4,
    parameter int DIV_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             update_en,
    output logic [IDX_W-1:0] tap_idx,
    output logic             acc_clr,
    output logic             mac_en,
    output logic             err_latch,
    output logic             upd_issue,
    output logic [IDX_W-1:0] upd_idx,
    output logic             wb_en,
    output logic [IDX_W-1:0] wb_idx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILT,
        S_ERR,
        S_UPD,
        S_DRAIN,
        S_DONE
    } state_t;

    // Phase counter is shared by FILT, UPD and DRAIN, so size it for the longest.
    localparam int PH_MAX = (NTAPS > DIV_LAT) ? NTAPS : DIV_LAT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] LAST_TAP   = PH_W'(NTAPS - 1);
    localparam logic [PH_W-1:0] LAST_DRAIN = PH_W'(DIV_LAT - 1);

    state_t                        state_q, state_d;
    logic [PH_W-1:0]               ph_q, ph_d;
    logic [CNT_W-1:0]              iter_q, iter_d;
    logic [DIV_LAT-1:0]            wb_vld_q;
    logic [DIV_LAT-1:0][IDX_W-1:0] wb_idx_q;

    // State, phase counter and iteration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state logic; the phase counter restarts at 0 on every state change.
    always_comb begin
        state_d = state_q;
        ph_d    = '0;
        iter_d  = iter_q;
        unique case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_FILT;
            S_FILT: begin
                if (ph_q == LAST_TAP) state_d = S_ERR;
                else                  ph_d    = ph_q + PH_W'(1);
            end
            S_ERR:   state_d = update_en ? S_UPD : S_DONE;
            S_UPD: begin
                if (ph_q == LAST_TAP) state_d = S_DRAIN;
                else                  ph_d    = ph_q + PH_W'(1);
            end
            S_DRAIN: begin
                if (ph_q == LAST_DRAIN) state_d = S_DONE;
                else                    ph_d    = ph_q + PH_W'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
                iter_d  = iter_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-back delay line: shifts every cycle so it tracks the DIV pipe exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld_q <= '0;
            wb_idx_q <= '0;
        end else begin
            wb_vld_q[0] <= upd_issue;
            wb_idx_q[0] <= upd_idx;
            for (int i = DIV_LAT - 1; i > 0; i--) begin
                wb_vld_q[i] <= wb_vld_q[i-1];
                wb_idx_q[i] <= wb_idx_q[i-1];
            end
        end
    end

    // Output decode. acc_clr is the only handshake-qualified output: the
    // accumulator must be cleared in the acceptance cycle itself.
    assign sample_ready = (state_q == S_IDLE) && !rst;
    assign acc_clr      = sample_ready && sample_valid;
    assign mac_en       = (state_q == S_FILT);
    assign tap_idx      = mac_en ? IDX_W'(ph_q) : '0;
    assign err_latch    = (state_q == S_ERR);
    assign upd_issue    = (state_q == S_UPD);
    assign upd_idx      = upd_issue ? IDX_W'(ph_q) : '0;
    assign wb_en        = wb_vld_q[DIV_LAT-1];
    assign wb_idx       = wb_en ? wb_idx_q[DIV_LAT-1] : '0;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign iter_cnt     = iter_q;

endmodule
